frequency_timer: RTL and testbench



---
 rtl/frequency_timer_if.sv | 19 +
 rtl/frequency_timer.sv | 60 ++++++
 tb/tb_frequency_timer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/frequency_timer_if.sv
// Bundle between the audio channel and its frequency timer: the channel
// drives the divide ratio, the timer returns the square wave and its count.
interface frequency_timer_if;
    logic [12:0] period;       // divide ratio in system clock cycles, 0 encodes 8192
    logic        timer_clock;  // registered square wave, one rising edge per period
    logic [12:0] count;        // current cycle counter, exposed for observation

    modport master (
        output period,
        input  timer_clock,
        input  count
    );

    modport slave (
        input  period,
        output timer_clock,
        output count
    );
endinterface

// File: rtl/frequency_timer.sv
// Programmable clock divider for the audio channels. Produces a square wave
// whose period P is a programmable number of system clock cycles: low for
// P - floor(P/2) cycles, then high for floor(P/2) cycles. The period input is
// sampled every cycle, so a new ratio takes effect on the very next edge.
//
// Interface handshake: there is no valid/ready pair; period is treated as
// always valid and is consumed on every rising edge of system_clock, and
// timer_clock/count are always valid outputs of registered state.
module frequency_timer (
    input  logic             system_clock,
    input  logic             reset,
    frequency_timer_if.slave tmr
);

    logic [13:0] p_eff;       // effective period, 14 bits so that 8192 fits
    logic [13:0] last_idx;    // P - 1, the wrap point of the counter
    logic [13:0] low_len;     // length of the low phase, P - floor(P/2)
    logic [12:0] count_q;
    logic [12:0] count_next;
    logic        timer_q;
    logic        timer_next;

    // Decode the effective period and compute next counter and output values.
    always_comb begin
        p_eff = {1'b0, tmr.period};
        if (tmr.period == 13'd0) begin
            p_eff = 14'd8192;
        end else if (tmr.period == 13'd1) begin
            // A period of one cycle cannot carry an edge; run as two instead.
            p_eff = 14'd2;
        end

        last_idx = p_eff - 14'd1;
        low_len  = p_eff - {1'b0, p_eff[13:1]};

        // Greater-or-equal also catches a count stranded above a newly shrunk period.
        if ({1'b0, count_q} >= last_idx) begin
            count_next = 13'd0;
        end else begin
            count_next = count_q + 13'd1;
        end

        timer_next = ({1'b0, count_next} >= low_len);
    end

    // Counter and output register; reset clears both without waiting for a clock.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            count_q <= 13'd0;
            timer_q <= 1'b0;
        end else begin
            count_q <= count_next;
            timer_q <= timer_next;
        end
    end

    assign tmr.timer_clock = timer_q;
    assign tmr.count       = count_q;

endmodule

// File: tb/tb_frequency_timer.sv
// Directed bench for frequency_timer: reset behaviour, steady-state periods,
// the 8192 encoding, clamped small periods and mid-count period changes.
module tb_frequency_timer;

  logic clk;
  logic reset;

  int assert_count;
  int fail_count;

  // per-phase edge/rise bookkeeping
  int   edge_num;
  int   rise_count;
  int   first_rise_edge;
  int   last_rise_edge;
  logic prev_tc;

  frequency_timer_if tif ();

  frequency_timer dut (
    .system_clock (clk),
    .reset        (reset),
    .tmr          (tif)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_phase();
    edge_num        = 0;
    rise_count      = 0;
    first_rise_edge = -1;
    last_rise_edge  = -1;
    prev_tc         = tif.timer_clock;
  endtask

  // run n edges; expected count is (offset + i) mod p, output high once count >= p - p/2
  task automatic run_check(input string tag, input int p, input int n, input int offset);
    int exp_cnt;
    int low_len;
    low_len = p - (p / 2);
    for (int i = 1; i <= n; i++) begin
      tick();
      edge_num++;
      exp_cnt = (offset + i) % p;
      check({tag, "_count"}, {19'd0, tif.count}, exp_cnt);
      check({tag, "_tc"}, {31'd0, tif.timer_clock}, (exp_cnt >= low_len) ? 32'd1 : 32'd0);
      if (!prev_tc && tif.timer_clock) begin
        rise_count++;
        if (first_rise_edge < 0) first_rise_edge = edge_num;
        last_rise_edge = edge_num;
      end
      prev_tc = tif.timer_clock;
    end
  endtask

  // hold reset for two edges with the given period, then release
  task automatic apply_reset(input logic [12:0] p);
    reset      = 1'b1;
    tif.period = p;
    #1;
    check("rst_async_count", {19'd0, tif.count}, 32'd0);
    check("rst_async_tc", {31'd0, tif.timer_clock}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_hold_count", {19'd0, tif.count}, 32'd0);
      check("rst_hold_tc", {31'd0, tif.timer_clock}, 32'd0);
    end
    reset = 1'b0;
    start_phase();
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    reset        = 1'b1;
    tif.period   = 13'd4;

    // reset held for three cycles with period 4
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_count", {19'd0, tif.count}, 32'd0);
      check("reset_tc", {31'd0, tif.timer_clock}, 32'd0);
    end
    reset = 1'b0;
    start_phase();

    // period 4 for 320 cycles: rises at 2, 6, 10, ... -> 80 rises
    run_check("p4", 4, 320, 0);
    check("p4_rises", rise_count, 32'd80);
    check("p4_first_rise", first_rise_edge, 32'd2);
    check("p4_last_rise", last_rise_edge, 32'd318);

    // bring the output high, then reset asynchronously mid-period
    run_check("p4_pre", 4, 2, 0);
    check("pre_async_tc", {31'd0, tif.timer_clock}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_drop_tc", {31'd0, tif.timer_clock}, 32'd0);
    check("async_drop_count", {19'd0, tif.count}, 32'd0);

    // period 5: low 3 / high 2, rises at 3, 8, 13, 18
    apply_reset(13'd5);
    run_check("p5", 5, 20, 0);
    check("p5_rises", rise_count, 32'd4);
    check("p5_first_rise", first_rise_edge, 32'd3);
    check("p5_last_rise", last_rise_edge, 32'd18);

    // period 1 behaves as 2: toggles every cycle, rises at 1, 3, 5, 7, 9
    apply_reset(13'd1);
    run_check("p1", 2, 10, 0);
    check("p1_rises", rise_count, 32'd5);
    check("p1_first_rise", first_rise_edge, 32'd1);

    // period 2: same pattern as period 1
    apply_reset(13'd2);
    run_check("p2", 2, 10, 0);
    check("p2_rises", rise_count, 32'd5);
    check("p2_first_rise", first_rise_edge, 32'd1);

    // period 100 switched to 4 at count 50: wraps to 0 on the next edge
    apply_reset(13'd100);
    run_check("p100", 100, 50, 0);
    check("p100_at50_count", {19'd0, tif.count}, 32'd50);
    tif.period = 13'd4;
    start_phase();
    run_check("p100to4", 4, 12, 3);
    check("p100to4_rises", rise_count, 32'd3);
    check("p100to4_first_rise", first_rise_edge, 32'd3);

    // period 4 switched to 8 at count 1: continues 2..7, rises at count 4
    apply_reset(13'd4);
    run_check("p4b", 4, 1, 0);
    tif.period = 13'd8;
    start_phase();
    run_check("p4to8", 8, 7, 1);
    check("p4to8_rises", rise_count, 32'd1);
    check("p4to8_rise_edge", first_rise_edge, 32'd3);

    // period 0 encodes 8192: first rise at 4096, next at 12288
    apply_reset(13'd0);
    run_check("p8192", 8192, 12288, 0);
    check("p8192_rises", rise_count, 32'd2);
    check("p8192_first_rise", first_rise_edge, 32'd4096);
    check("p8192_second_rise", last_rise_edge, 32'd12288);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
